cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter for four functional units.
// Each unit (add, mul, div, br) completes into its own small in-order FIFO.
// A round-robin pointer picks at most one non-empty FIFO per cycle and
// broadcasts its head entry on a registered CDB. A flush drops every
// buffered result.
module cdb_arbiter #(
    parameter int QUEUE_DEPTH = 64,
    parameter int FIFO_DEPTH  = 2,
    localparam int IDXW       = $clog2(QUEUE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        fu_valid,
    output logic [3:0]        fu_ready,
    input  logic [4*IDXW-1:0] fu_rob_idx,
    input  logic [4*6-1:0]    fu_pd,
    input  logic [4*32-1:0]   fu_rd_wdata,
    input  logic [3:0]        fu_regf_we,
    input  logic              flush,
    output logic              cdb_valid,
    output logic [1:0]        cdb_src,
    output logic [IDXW-1:0]   cdb_rob_idx,
    output logic [5:0]        cdb_pd,
    output logic [31:0]       cdb_rd_wdata,
    output logic              cdb_regf_we
);

    // Entry layout: {regf_we, rd_wdata, pd, rob_idx}
    localparam int ENTW = IDXW + 6 + 32 + 1;
    // A depth-1 FIFO still needs a 1-bit pointer to index its storage
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    // Advance a FIFO pointer, wrapping at the last slot
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    logic [ENTW-1:0] mem_q    [4][FIFO_DEPTH];
    logic [ENTW-1:0] mem_d    [4][FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q [4];
    logic [PW-1:0]   wr_ptr_d [4];
    logic [PW-1:0]   rd_ptr_q [4];
    logic [PW-1:0]   rd_ptr_d [4];
    logic [CW-1:0]   cnt_q    [4];
    logic [CW-1:0]   cnt_d    [4];
    logic [1:0]      rr_ptr_q;
    logic [1:0]      rr_ptr_d;

    logic            cdb_valid_q,    cdb_valid_d;
    logic [1:0]      cdb_src_q,      cdb_src_d;
    logic [IDXW-1:0] cdb_rob_idx_q,  cdb_rob_idx_d;
    logic [5:0]      cdb_pd_q,       cdb_pd_d;
    logic [31:0]     cdb_rd_wdata_q, cdb_rd_wdata_d;
    logic            cdb_regf_we_q,  cdb_regf_we_d;

    logic [3:0]      ready_s;
    logic [3:0]      nonempty_s;
    logic [3:0]      push_s;
    logic [3:0]      pop_s;
    logic            win_found_s;
    logic [1:0]      win_idx_s;
    logic [1:0]      cand_s;
    logic [ENTW-1:0] head_s;

    // Per-unit acceptance and occupancy, from registered state only
    always_comb begin
        ready_s    = 4'b0000;
        nonempty_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ready_s[i]    = rst & (cnt_q[i] < DEPTH_C);
            nonempty_s[i] = (cnt_q[i] != {CW{1'b0}});
        end
    end

    assign fu_ready = ready_s;

    // Round-robin pick: scan from rr_ptr upward; scanning in reverse lets the
    // nearest non-empty candidate be the last one written
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 2'd0;
        cand_s      = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand_s      = rr_ptr_q + 2'(k);
            win_found_s = win_found_s | nonempty_s[cand_s];
            win_idx_s   = nonempty_s[cand_s] ? cand_s : win_idx_s;
        end
    end

    // Head entry of the winning FIFO
    always_comb begin
        head_s = mem_q[win_idx_s][rd_ptr_q[win_idx_s]];
    end

    // Next state for FIFOs, round-robin pointer and CDB registers
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        rr_ptr_d       = rr_ptr_q;
        cdb_valid_d    = 1'b0;
        cdb_src_d      = cdb_src_q;
        cdb_rob_idx_d  = cdb_rob_idx_q;
        cdb_pd_d       = cdb_pd_q;
        cdb_rd_wdata_d = cdb_rd_wdata_q;
        cdb_regf_we_d  = cdb_regf_we_q;
        push_s         = fu_valid & ready_s;
        pop_s          = 4'b0000;

        if (flush) begin
            // Flush beats push and grant; rr_ptr and payload are held
            for (int i = 0; i < 4; i++) begin
                cnt_d[i]    = {CW{1'b0}};
                wr_ptr_d[i] = {PW{1'b0}};
                rd_ptr_d[i] = {PW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                pop_s[i] = win_found_s & (win_idx_s == 2'(i));
            end

            for (int i = 0; i < 4; i++) begin
                if (push_s[i]) begin
                    mem_d[i][wr_ptr_q[i]] = {fu_regf_we[i],
                                             fu_rd_wdata[i*32 +: 32],
                                             fu_pd[i*6 +: 6],
                                             fu_rob_idx[i*IDXW +: IDXW]};
                    wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
                end else begin
                    wr_ptr_d[i] = wr_ptr_q[i];
                end

                if (pop_s[i]) begin
                    rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
                end else begin
                    rd_ptr_d[i] = rd_ptr_q[i];
                end

                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                    2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end

            if (win_found_s) begin
                cdb_valid_d    = 1'b1;
                cdb_src_d      = win_idx_s;
                cdb_rob_idx_d  = head_s[IDXW-1:0];
                cdb_pd_d       = head_s[IDXW +: 6];
                cdb_rd_wdata_d = head_s[IDXW+6 +: 32];
                cdb_regf_we_d  = head_s[ENTW-1];
                rr_ptr_d       = win_idx_s + 2'd1;
            end else begin
                cdb_valid_d    = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= {ENTW{1'b0}};
                end
                wr_ptr_q[i] <= {PW{1'b0}};
                rd_ptr_q[i] <= {PW{1'b0}};
                cnt_q[i]    <= {CW{1'b0}};
            end
            rr_ptr_q       <= 2'd0;
            cdb_valid_q    <= 1'b0;
            cdb_src_q      <= 2'd0;
            cdb_rob_idx_q  <= {IDXW{1'b0}};
            cdb_pd_q       <= 6'd0;
            cdb_rd_wdata_q <= 32'd0;
            cdb_regf_we_q  <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_src_q      <= cdb_src_d;
            cdb_rob_idx_q  <= cdb_rob_idx_d;
            cdb_pd_q       <= cdb_pd_d;
            cdb_rd_wdata_q <= cdb_rd_wdata_d;
            cdb_regf_we_q  <= cdb_regf_we_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_src      = cdb_src_q;
    assign cdb_rob_idx  = cdb_rob_idx_q;
    assign cdb_pd       = cdb_pd_q;
    assign cdb_rd_wdata = cdb_rd_wdata_q;
    assign cdb_regf_we  = cdb_regf_we_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed-vector bench for cdb_arbiter with hand-computed
// expected broadcast sequences (QUEUE_DEPTH=64, FIFO_DEPTH=2).
module tb_cdb_arbiter;

    localparam int IDXW = 6;

    logic              clk;
    logic              rst;
    logic [3:0]        fu_valid;
    logic [3:0]        fu_ready;
    logic [4*IDXW-1:0] fu_rob_idx;
    logic [4*6-1:0]    fu_pd;
    logic [4*32-1:0]   fu_rd_wdata;
    logic [3:0]        fu_regf_we;
    logic              flush;
    logic              cdb_valid;
    logic [1:0]        cdb_src;
    logic [IDXW-1:0]   cdb_rob_idx;
    logic [5:0]        cdb_pd;
    logic [31:0]       cdb_rd_wdata;
    logic              cdb_regf_we;

    int n_total;
    int n_bad;

    cdb_arbiter #(.QUEUE_DEPTH(64), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .fu_valid     (fu_valid),
        .fu_ready     (fu_ready),
        .fu_rob_idx   (fu_rob_idx),
        .fu_pd        (fu_pd),
        .fu_rd_wdata  (fu_rd_wdata),
        .fu_regf_we   (fu_regf_we),
        .flush        (flush),
        .cdb_valid    (cdb_valid),
        .cdb_src      (cdb_src),
        .cdb_rob_idx  (cdb_rob_idx),
        .cdb_pd       (cdb_pd),
        .cdb_rd_wdata (cdb_rd_wdata),
        .cdb_regf_we  (cdb_regf_we)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and samples both land 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int u, input logic [5:0] rob, input logic [5:0] pd,
                            input logic [31:0] data, input logic we);
        fu_rob_idx[u*IDXW +: IDXW] = rob;
        fu_pd[u*6 +: 6]            = pd;
        fu_rd_wdata[u*32 +: 32]    = data;
        fu_regf_we[u]              = we;
    endtask

    task automatic do_reset();
        fu_valid = 4'b0000;
        flush    = 1'b0;
        rst      = 1'b0;
        step();
        rst      = 1'b1;
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        fu_valid    = 4'b1111;
        fu_rob_idx  = '0;
        fu_pd       = '0;
        fu_rd_wdata = '0;
        fu_regf_we  = 4'b0000;
        for (int u = 0; u < 4; u++) set_unit(u, 6'(u + 40), 6'(u), 32'hA5A5_0000 + 32'(u), 1'b1);

        // Reset held two cycles with every unit requesting
        step();
        check_eq("rst_valid_1", 64'(cdb_valid), 64'd0);
        check_eq("rst_ready_1", 64'(fu_ready), 64'h0);
        step();
        check_eq("rst_valid_2", 64'(cdb_valid), 64'd0);
        check_eq("rst_ready_2", 64'(fu_ready), 64'h0);
        check_eq("rst_src", 64'(cdb_src), 64'd0);
        check_eq("rst_data", 64'(cdb_rd_wdata), 64'd0);
        rst      = 1'b1;
        fu_valid = 4'b0000;
        #1;
        check_eq("rel_ready", 64'(fu_ready), 64'hF);
        step();
        check_eq("rel_valid", 64'(cdb_valid), 64'd0);
        check_eq("rel_ready_2", 64'(fu_ready), 64'hF);

        // Single add completion: broadcast two edges after the push
        set_unit(0, 6'd5, 6'd12, 32'hDEAD_BEEF, 1'b1);
        fu_valid = 4'b0001;
        step();
        fu_valid = 4'b0000;
        check_eq("single_n1_valid", 64'(cdb_valid), 64'd0);
        step();
        check_eq("single_valid", 64'(cdb_valid), 64'd1);
        check_eq("single_src", 64'(cdb_src), 64'd0);
        check_eq("single_rob", 64'(cdb_rob_idx), 64'd5);
        check_eq("single_pd", 64'(cdb_pd), 64'd12);
        check_eq("single_data", 64'(cdb_rd_wdata), 64'hDEADBEEF);
        check_eq("single_we", 64'(cdb_regf_we), 64'd1);
        step();
        check_eq("single_after_valid", 64'(cdb_valid), 64'd0);
        check_eq("single_after_hold", 64'(cdb_rob_idx), 64'd5);

        // All four push together from rr_ptr=0
        do_reset();
        for (int u = 0; u < 4; u++) set_unit(u, 6'(10 + u), 6'(20 + u), 32'h1111 * 32'(u + 1), u[0]);
        fu_valid = 4'b1111;
        step();
        fu_valid = 4'b0000;
        for (int u = 0; u < 4; u++) begin
            step();
            check_eq($sformatf("all4_valid_%0d", u), 64'(cdb_valid), 64'd1);
            check_eq($sformatf("all4_src_%0d", u), 64'(cdb_src), 64'(u));
            check_eq($sformatf("all4_rob_%0d", u), 64'(cdb_rob_idx), 64'(10 + u));
            check_eq($sformatf("all4_data_%0d", u), 64'(cdb_rd_wdata), 64'(32'h1111 * 32'(u + 1)));
            check_eq($sformatf("all4_we_%0d", u), 64'(cdb_regf_we), 64'(u % 2));
        end
        step();
        check_eq("all4_idle", 64'(cdb_valid), 64'd0);
        // rr_ptr should be back at 0: a fresh mul+add push must grant add first
        set_unit(0, 6'd30, 6'd1, 32'h0, 1'b0);
        set_unit(1, 6'd31, 6'd2, 32'h0, 1'b0);
        fu_valid = 4'b0011;
        step();
        fu_valid = 4'b0000;
        step();
        check_eq("rr_wrap_src0", 64'(cdb_src), 64'd0);
        step();
        check_eq("rr_wrap_src1", 64'(cdb_src), 64'd1);

        // Fairness: add and br always requesting
        do_reset();
        set_unit(0, 6'd1, 6'd1, 32'h100, 1'b1);
        set_unit(3, 6'd3, 6'd3, 32'h300, 1'b0);
        fu_valid = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k >= 1) begin
                check_eq($sformatf("fair_valid_%0d", k), 64'(cdb_valid), 64'd1);
                check_eq($sformatf("fair_src_%0d", k), 64'(cdb_src), (k % 2 == 1) ? 64'd0 : 64'd3);
            end
        end
        fu_valid = 4'b0000;

        // Full div FIFO while the other units keep the bus busy
        do_reset();
        set_unit(0, 6'd1, 6'd0, 32'h0, 1'b1);
        set_unit(1, 6'd2, 6'd0, 32'h0, 1'b1);
        set_unit(2, 6'd20, 6'd7, 32'hD1, 1'b1);
        set_unit(3, 6'd3, 6'd0, 32'h0, 1'b1);
        fu_valid = 4'b1111;
        step();                                   // E1
        set_unit(0, 6'd4, 6'd0, 32'h0, 1'b1);
        set_unit(1, 6'd5, 6'd0, 32'h0, 1'b1);
        set_unit(2, 6'd21, 6'd8, 32'hD2, 1'b1);
        set_unit(3, 6'd6, 6'd0, 32'h0, 1'b1);
        step();                                   // E2
        check_eq("full_e2_src", 64'(cdb_src), 64'd0);
        check_eq("full_e2_rob", 64'(cdb_rob_idx), 64'd1);
        check_eq("full_ready_div_1", 64'(fu_ready[2]), 64'd0);
        set_unit(2, 6'd22, 6'd9, 32'hD3, 1'b1);
        fu_valid = 4'b0100;
        step();                                   // E3
        check_eq("full_e3_rob", 64'(cdb_rob_idx), 64'd2);
        check_eq("full_ready_div_2", 64'(fu_ready[2]), 64'd0);
        step();                                   // E4
        fu_valid = 4'b0000;
        check_eq("full_e4_src", 64'(cdb_src), 64'd2);
        check_eq("full_e4_rob", 64'(cdb_rob_idx), 64'd20);
        check_eq("full_e4_data", 64'(cdb_rd_wdata), 64'hD1);
        begin
            logic [5:0] exp_rob [5];
            exp_rob[0] = 6'd3; exp_rob[1] = 6'd4; exp_rob[2] = 6'd5;
            exp_rob[3] = 6'd21; exp_rob[4] = 6'd6;
            for (int k = 0; k < 5; k++) begin
                step();                           // E5..E9
                check_eq($sformatf("full_seq_valid_%0d", k), 64'(cdb_valid), 64'd1);
                check_eq($sformatf("full_seq_rob_%0d", k), 64'(cdb_rob_idx), 64'(exp_rob[k]));
            end
        end
        step();                                   // E10: D3 was never stored
        check_eq("full_no_d3", 64'(cdb_valid), 64'd0);

        // Flush with three entries buffered, plus a same-cycle push
        do_reset();
        for (int u = 0; u < 4; u++) set_unit(u, 6'(50 + u), 6'(u), 32'hF000 + 32'(u), 1'b1);
        fu_valid = 4'b0111;
        step();
        fu_valid = 4'b1000;
        flush    = 1'b1;
        step();
        fu_valid = 4'b0000;
        flush    = 1'b0;
        check_eq("flush_valid", 64'(cdb_valid), 64'd0);
        check_eq("flush_ready", 64'(fu_ready), 64'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("flush_quiet_%0d", k), 64'(cdb_valid), 64'd0);
        end

        // Reset mid-operation discards buffered entries
        fu_valid = 4'b0011;
        step();
        fu_valid = 4'b0000;
        rst      = 1'b0;
        step();
        rst      = 1'b1;
        step();
        check_eq("midrst_quiet_1", 64'(cdb_valid), 64'd0);
        step();
        check_eq("midrst_quiet_2", 64'(cdb_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
